// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpHalt = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpSll  = 3'b100,
    OpSrl  = 3'b101,
    OpAddi = 3'b110,
    OpSubi = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StHalt      = 3'd4
  } state_e;

  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 29;
  localparam int unsigned RdMsb  = 28;
  localparam int unsigned RdLsb  = 24;
  localparam int unsigned RsMsb  = 23;
  localparam int unsigned RsLsb  = 19;
  localparam int unsigned RtMsb  = 18;
  localparam int unsigned RtLsb  = 14;
  localparam int unsigned ImmMsb = 13;
  localparam int unsigned ImmLsb = 0;
  localparam int unsigned ImmW   = ImmMsb - ImmLsb + 1;

  typedef struct packed {
    opcode_e     op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        src_imm;
  } decode_t;

  function automatic logic [31:0] sext_imm(input logic [ImmW-1:0] v);
    return {{(32 - ImmW){v[ImmW-1]}}, v};
  endfunction

  function automatic logic uses_imm(input opcode_e op);
    return (op == OpAddi) || (op == OpSubi);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-memory fetch handshake between the control FSM and memory.
interface multicycle_control_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_decode.sv
// Combinational field extraction and immediate sign extension.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  always_comb begin
    dec_o         = '0;
    dec_o.op      = opcode_e'(instr_i[OpMsb:OpLsb]);
    dec_o.rd      = instr_i[RdMsb:RdLsb];
    dec_o.rs      = instr_i[RsMsb:RsLsb];
    dec_o.rt      = instr_i[RtMsb:RtLsb];
    dec_o.imm     = sext_imm(instr_i[ImmMsb:ImmLsb]);
    dec_o.src_imm = uses_imm(opcode_e'(instr_i[OpMsb:OpLsb]));
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle fetch/decode/execute/writeback control FSM with program counter.
// Decode outputs come straight from the instruction register, so they hold until the next fetch.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master imem,
  output logic [2:0]           alu_op,
  output logic                 alu_src_imm,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [31:0]          imm,
  output logic                 reg_we,
  output logic                 halted,
  output logic [31:0]          pc
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        halted_q, halted_d;
  decode_t     dec;

  instr_decode u_decode (
    .instr_i (ir_q),
    .dec_o   (dec)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    req_d    = req_q;
    we_d     = 1'b0;
    halted_d = halted_q;
    unique case (state_q)
      StFetch: begin
        req_d = 1'b1;
        // req_q gates acceptance so the reset-release cycle never latches a word.
        if (req_q && imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          req_d   = 1'b0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (dec.op)
          OpHalt: begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
          OpNop: begin
            pc_d    = pc_q + 32'd4;
            req_d   = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StExecute;
        endcase
      end
      StExecute: begin
        state_d = StWriteback;
        we_d    = (dec.rd != 5'd0);
      end
      StWriteback: begin
        pc_d    = pc_q + 32'd4;
        req_d   = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = StFetch;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      we_q     <= we_d;
      halted_q <= halted_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign reg_we         = we_q;
  assign halted         = halted_q;
  assign alu_op         = dec.op;
  assign alu_src_imm    = dec.src_imm;
  assign rs             = dec.rs;
  assign rt             = dec.rt;
  assign rd             = dec.rd;
  assign imm            = dec.imm;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have ports clk, input, 1, the single system clock.
REQ-003 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have imem_req, output, 1, fetch request, held until accepted.
REQ-005 SHALL have imem_addr, output, 32, fetch address (equals pc).
REQ-006 SHALL have imem_ack, input, 1, instruction valid this cycle.
REQ-007 SHALL have imem_rdata, input, 32, instruction word.
REQ-008 SHALL have alu_op, output, 3, operation code to ALU.
REQ-009 SHALL have alu_src_imm, output, 1; 1 selects imm as ALU b.
REQ-010 SHALL have rs, rt, rd, output, 5 each, register indices.
REQ-011 SHALL have imm, output, 32, sign-extended immediate.
REQ-012 SHALL have reg_we, output, 1, register-file write strobe, one cycle.
REQ-013 SHALL have halted, output, 1, core stopped.
REQ-014 SHALL have pc, output, 32, current instruction address.

Function
REQ-015 SHALL decode fields: op=instr[31:29], rd=[28:24], rs=[23:19], rt=[18:14], imm=sign-extend(instr[13:0]).
REQ-016 SHALL define opcodes: 000 NOP, 001 HALT, 010 ADD, 011 SUB, 100 SLL, 101 SRL, 110 ADDI, 111 SUBI; alu_op SHALL equal op.
REQ-017 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-018 FETCH: imem_req=1; on imem_ack latch imem_rdata into instruction register, go DECODE; without ack, stay in FETCH with addr stable.
REQ-019 DECODE (1 cycle): drive rs/rt/rd/imm/alu_op/alu_src_imm from latched instruction; HALT -> HALT state; NOP -> FETCH with pc+4; else -> EXECUTE.
REQ-020 EXECUTE (1 cycle): hold decode outputs; alu_src_imm=1 only for ADDI/SUBI; go WRITEBACK.
REQ-021 WRITEBACK: reg_we=1 for exactly one cycle unless rd==0 (write suppressed); pc<=pc+4 (modulo 2^32, wraps to 0); go FETCH.
REQ-022 Latency: ALU instruction = 4 cycles from ack to next imem_req; NOP = 2 cycles.
REQ-023 HALT: halted=1, imem_req=0, reg_we=0; exit only by reset.
REQ-024 imem_ack outside FETCH SHALL be ignored.
REQ-025 Decode outputs SHALL be held stable from DECODE through WRITEBACK.

Reset
REQ-026 On rst_n=0 (any state, incl. mid-fetch) SHALL go FETCH immediately: pc=RESET_PC, imem_req=0 while asserted, reg_we=0, halted=0, alu_op=000, alu_src_imm=0, rs/rt/rd=0, imm=0, instruction register=0.
REQ-027 First imem_req SHALL assert the first clk edge after rst_n deasserts.

Structure
REQ-028 Opcode constants, state encoding and field bit positions SHALL live in a shared package cpu_pkg, also used by the ALU.
REQ-029 One sub-module instr_decode (combinational field extraction and sign extension) SHALL be instantiated; FSM and pc stay in top.

Verification
REQ-030 ADD r3,r1,r2 (32'h4308_8000) with immediate ack -> alu_op=010, alu_src_imm=0, rd=3, one reg_we pulse, pc 0->4.
REQ-031 ADDI r1,r0,-1 (imm=14'h3FFF) -> imm=32'hFFFF_FFFF, alu_src_imm=1, alu_op=110.
REQ-032 Ack delayed 5 cycles -> imem_req held high, imem_addr stable, no reg_we.
REQ-033 HALT (32'h2000_0000) -> halted=1 after DECODE, no further imem_req for 20 cycles.
REQ-034 rst_n low during EXECUTE -> outputs at reset values asynchronously, restart fetch at RESET_PC.
REQ-035 pc=32'hFFFF_FFFC, SUB to rd=0 -> no reg_we, pc wraps to 0.
